cbus_write_sequencer: RTL and testbench

- Write-side driver for the C bus: the producer end that feeds the negedge-capturing register file, one destination per cycle.
- Accepts write-back requests (destination code + 32-bit data) from the datapath/control unit through a valid/ready handshake.
- Buffers requests in a small FIFO and drives cbus_en/cbus_out from registers, so each word is stable across the following negedge capture.
- Decouples producers that burst results (ALU, load path) from the single-write-per-cycle C bus.

---
 rtl/cbus_write_sequencer_pkg.sv | 25 ++
 rtl/cbus_write_sequencer_sync_fifo.sv | 66 ++++++
 rtl/cbus_write_sequencer.sv | 94 +++++++++
 tb/tb_cbus_write_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_write_sequencer_pkg
// Description : Shared widths and destination codes for the C-bus write side.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_write_sequencer_pkg;

    // C-bus geometry
    localparam int CBUS_EN_W   = 4;
    localparam int CBUS_DATA_W = 32;

    // Enable code meaning "no register is written this cycle"
    localparam logic [CBUS_EN_W-1:0] CBUS_IDLE = 4'b0000;

    // Destination code for register reg1
    localparam logic [CBUS_EN_W-1:0] DEST_REG1 = 4'b0100;

    // Counter width able to hold 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_write_sequencer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cbus_write_sequencer_sync_fifo
// Description : Single-clock FIFO with occupancy count and synchronous flush.
//               Full/empty is decided from the count, never pointer equality.
//               The caller must not push when full nor pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_write_sequencer_sync_fifo
    import cbus_write_sequencer_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic                        flush_i,
    input  logic [WIDTH-1:0]            wdata_i,
    output logic [WIDTH-1:0]            head_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers and count; flush wins over push and pop. Power-of-two depth
    // lets the pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage array; no reset needed because a slot is only read after it was written
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cbus_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cbus_write_sequencer
// Description : Write-side driver for the C bus. Buffers write-back requests
//               in a FIFO and drives one registered destination per cycle so
//               each word is stable across the register file's negedge capture.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_write_sequencer
    import cbus_write_sequencer_pkg::*;
#(
    parameter int                  DEPTH     = 4,
    parameter int                  DATA_W    = CBUS_DATA_W,
    parameter int                  EN_W      = CBUS_EN_W,
    parameter logic [EN_W-1:0]     IDLE_CODE = CBUS_IDLE
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_valid,
    input  logic [EN_W-1:0]               wr_dest,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          stall,
    input  logic                          flush,
    output logic [EN_W-1:0]               cbus_en,
    output logic [DATA_W-1:0]             cbus_out,
    output logic [count_width(DEPTH)-1:0] pending
);

    localparam int                CNT_W  = count_width(DEPTH);
    localparam int                WORD_W = EN_W + DATA_W;
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  w_count;
    logic [WORD_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;

    logic [EN_W-1:0]   cbus_en_q;
    logic [EN_W-1:0]   cbus_en_d;
    logic [DATA_W-1:0] cbus_out_q;
    logic [DATA_W-1:0] cbus_out_d;

    // Ready depends only on registered occupancy, so a full FIFO refuses even
    // when a pop happens in the same cycle.
    assign wr_ready = (w_count != C_FULL);

    // Idle-code requests are handshaken but never stored
    assign w_push = wr_valid && wr_ready && !flush && (wr_dest != IDLE_CODE);

    // No bypass: only entries already queued before this edge can be issued
    assign w_pop  = !flush && !stall && (w_count != '0);

    cbus_write_sequencer_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (flush),
        .wdata_i ({wr_dest, wr_data}),
        .head_o  (w_head),
        .count_o (w_count)
    );

    // Next bus word: the FIFO head when popping, otherwise an idle cycle with zero data
    always_comb begin
        cbus_en_d  = IDLE_CODE;
        cbus_out_d = '0;
        if (w_pop) begin
            cbus_en_d  = w_head[WORD_W-1 -: EN_W];
            cbus_out_d = w_head[DATA_W-1:0];
        end
    end

    // Bus output register; async reset idles the bus before the next negedge capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cbus_en_q  <= IDLE_CODE;
            cbus_out_q <= '0;
        end else begin
            cbus_en_q  <= cbus_en_d;
            cbus_out_q <= cbus_out_d;
        end
    end

    assign cbus_en  = cbus_en_q;
    assign cbus_out = cbus_out_q;
    assign pending  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_cbus_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_write_sequencer
// Description : Self-checking bench for cbus_write_sequencer against a
//               queue-based model of the C-bus write side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_write_sequencer;

    localparam int DEPTH = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_dest  = 4'h0;
    logic [31:0] wr_data  = 32'h0;
    logic        stall    = 1'b0;
    logic        flush    = 1'b0;
    logic        wr_ready;
    logic [3:0]  cbus_en;
    logic [31:0] cbus_out;
    logic [2:0]  pending;

    int tests = 0;
    int fails = 0;

    // Model state: queued words {dest,data} and the word currently on the bus
    logic [35:0] m_q [$];
    logic [3:0]  m_en  = 4'h0;
    logic [31:0] m_out = 32'h0;

    always #5 clock = ~clock;

    cbus_write_sequencer #(
        .DEPTH     (DEPTH),
        .DATA_W    (32),
        .EN_W      (4),
        .IDLE_CODE (4'b0000)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_valid (wr_valid),
        .wr_dest  (wr_dest),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .stall    (stall),
        .flush    (flush),
        .cbus_en  (cbus_en),
        .cbus_out (cbus_out),
        .pending  (pending)
    );

    function automatic logic [3:0] rand_dest();
        return 4'($urandom_range(1, 15));
    endfunction

    // Advance one clock edge and apply the write-side rules to the model
    task automatic step();
        bit          rdy;
        logic [35:0] w;
        rdy = (m_q.size() != DEPTH);
        @(posedge clock);
        if (flush) begin
            m_q.delete();
            m_en  = 4'h0;
            m_out = 32'h0;
        end else begin
            if (!stall && m_q.size() != 0) begin
                w     = m_q.pop_front();
                m_en  = w[35:32];
                m_out = w[31:0];
            end else begin
                m_en  = 4'h0;
                m_out = 32'h0;
            end
            if (wr_valid && rdy && wr_dest != 4'h0) m_q.push_back({wr_dest, wr_data});
        end
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_en  = 4'h0;
        m_out = 32'h0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests++; if (cbus_en !== 4'h0)   begin fails++; $display("FAIL reset_en got %h exp 0", cbus_en); end
        tests++; if (cbus_out !== 32'h0) begin fails++; $display("FAIL reset_out got %h exp 0", cbus_out); end
        tests++; if (pending !== 3'd0)   begin fails++; $display("FAIL reset_pending got %0d exp 0", pending); end
        tests++; if (wr_ready !== 1'b1)  begin fails++; $display("FAIL reset_ready got %b exp 1", wr_ready); end
        reset_n = 1'b1;
        model_reset();
        step();
        tests++; if (cbus_en !== 4'h0 || pending !== 3'd0) begin
            fails++; $display("FAIL post_reset_idle en %h pend %0d exp 0 0", cbus_en, pending);
        end
    endtask

    task automatic test_single();
        wr_valid = 1'b1; wr_dest = 4'b0100; wr_data = 32'hDEADBEEF;
        step();
        wr_valid = 1'b0;
        tests++; if (pending !== 3'd1 || cbus_en !== 4'h0) begin
            fails++; $display("FAIL single_n pend %0d en %h exp 1 0", pending, cbus_en);
        end
        step();
        tests++; if (cbus_en !== 4'b0100 || cbus_out !== 32'hDEADBEEF || pending !== 3'd0) begin
            fails++; $display("FAIL single_n1 en %h out %h pend %0d exp 4 deadbeef 0", cbus_en, cbus_out, pending);
        end
        step();
        tests++; if (cbus_en !== 4'h0 || cbus_out !== 32'h0) begin
            fails++; $display("FAIL single_n2 en %h out %h exp 0 0", cbus_en, cbus_out);
        end
    endtask

    task automatic test_fill_stall();
        logic [35:0] exp [4];
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp[i]   = {rand_dest(), 24'($urandom), 8'(i)};
            wr_valid = 1'b1; wr_dest = exp[i][35:32]; wr_data = exp[i][31:0];
            step();
        end
        tests++; if (wr_ready !== 1'b0 || pending !== 3'd4) begin
            fails++; $display("FAIL fill_full ready %b pend %0d exp 0 4", wr_ready, pending);
        end
        wr_dest = rand_dest(); wr_data = 32'hFFFF_0005;
        step();
        tests++; if (pending !== 3'd4 || cbus_en !== 4'h0 || m_q.size() != 4) begin
            fails++; $display("FAIL fill_fifth pend %0d en %h exp 4 0", pending, cbus_en);
        end
        wr_valid = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++; if ({cbus_en, cbus_out} !== exp[i] || pending !== 3'(3 - i)) begin
                fails++; $display("FAIL fill_drain%0d got %h/%0d exp %h/%0d", i, {cbus_en, cbus_out}, pending, exp[i], 3 - i);
            end
            if (i == 0) begin
                tests++; if (wr_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_after_pop got %b exp 1", wr_ready); end
            end
        end
        step();
        tests++; if (cbus_en !== 4'h0) begin fails++; $display("FAIL fill_idle got %h exp 0", cbus_en); end
    endtask

    task automatic test_back_to_back();
        logic [35:0] sent [$];
        logic [35:0] got  [$];
        int          gaps;
        bit          mism;
        gaps = 0; mism = 0;
        stall = 1'b0;
        for (int i = 0; i < 23; i++) begin
            if (i < 20) begin
                wr_valid = 1'b1; wr_dest = rand_dest(); wr_data = $urandom;
                sent.push_back({wr_dest, wr_data});
            end else begin
                wr_valid = 1'b0;
            end
            step();
            if (cbus_en !== m_en || cbus_out !== m_out || pending > 3'd1) mism = 1;
            if (cbus_en !== 4'h0) got.push_back({cbus_en, cbus_out});
            else if (i >= 1 && i <= 20) gaps++;
        end
        tests++; if (mism) begin fails++; $display("FAIL b2b_cycle bus or pending deviated from model, got flag %b exp 0", mism); end
        tests++; if (gaps != 0) begin fails++; $display("FAIL b2b_gaps got %0d exp 0", gaps); end
        tests++; if (got.size() != 20) begin fails++; $display("FAIL b2b_count got %0d exp 20", got.size()); end
        else begin
            for (int i = 0; i < 20; i++) begin
                tests++; if (got[i] !== sent[i]) begin fails++; $display("FAIL b2b_order%0d got %h exp %h", i, got[i], sent[i]); end
            end
        end
    endtask

    task automatic test_idle_drop();
        logic [35:0] seq [4];
        logic [35:0] a;
        logic [35:0] b;
        logic [2:0]  pend [4];
        a = {rand_dest(), 32'hAAAA_0001};
        b = {rand_dest(), 32'hBBBB_0002};
        stall = 1'b0;
        wr_valid = 1'b1; {wr_dest, wr_data} = a;                   step(); seq[0] = {cbus_en, cbus_out}; pend[0] = pending;
        {wr_dest, wr_data} = {4'b0000, 32'h0000_1234};             step(); seq[1] = {cbus_en, cbus_out}; pend[1] = pending;
        {wr_dest, wr_data} = b;                                    step(); seq[2] = {cbus_en, cbus_out}; pend[2] = pending;
        wr_valid = 1'b0;                                           step(); seq[3] = {cbus_en, cbus_out}; pend[3] = pending;
        tests++; if (seq[0] !== 36'h0 || seq[1] !== a || seq[2] !== 36'h0 || seq[3] !== b) begin
            fails++; $display("FAIL idle_drop_bus got %h %h %h %h exp 0 %h 0 %h", seq[0], seq[1], seq[2], seq[3], a, b);
        end
        tests++; if (pend[0] !== 3'd1 || pend[1] !== 3'd0 || pend[2] !== 3'd1 || pend[3] !== 3'd0) begin
            fails++; $display("FAIL idle_drop_pend got %0d %0d %0d %0d exp 1 0 1 0", pend[0], pend[1], pend[2], pend[3]);
        end
    endtask

    task automatic test_flush();
        bit leaked;
        leaked = 0;
        stall = 1'b1; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_dest = rand_dest(); wr_data = $urandom;
            step();
        end
        stall = 1'b0; wr_valid = 1'b0;
        step();
        tests++; if (pending !== 3'd3 || cbus_en === 4'h0) begin
            fails++; $display("FAIL flush_setup pend %0d en %h exp 3 nonzero", pending, cbus_en);
        end
        flush = 1'b1; wr_valid = 1'b1; wr_dest = 4'b0100; wr_data = 32'hF1F1_F1F1;
        step();
        flush = 1'b0; wr_valid = 1'b0;
        tests++; if (cbus_en !== 4'h0 || cbus_out !== 32'h0 || pending !== 3'd0 || wr_ready !== 1'b1) begin
            fails++; $display("FAIL flush_edge en %h out %h pend %0d rdy %b exp 0 0 0 1", cbus_en, cbus_out, pending, wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (cbus_en !== 4'h0 || cbus_out !== 32'h0) leaked = 1;
        end
        tests++; if (leaked) begin fails++; $display("FAIL flush_leak got %b exp 0", leaked); end
    endtask

    task automatic test_async_reset();
        logic [35:0] w;
        stall = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_dest = rand_dest(); wr_data = $urandom;
            step();
        end
        wr_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        tests++; if (cbus_en !== 4'h0 || cbus_out !== 32'h0 || pending !== 3'd0 || wr_ready !== 1'b1) begin
            fails++; $display("FAIL async_reset en %h out %h pend %0d rdy %b exp 0 0 0 1", cbus_en, cbus_out, pending, wr_ready);
        end
        model_reset();
        #2 reset_n = 1'b1;
        w = {rand_dest(), 32'h5A5A_0F0F};
        wr_valid = 1'b1; {wr_dest, wr_data} = w;
        step();
        wr_valid = 1'b0;
        step();
        tests++; if ({cbus_en, cbus_out} !== w || pending !== 3'd0) begin
            fails++; $display("FAIL post_reset_write got %h/%0d exp %h/0", {cbus_en, cbus_out}, pending, w);
        end
        step();
        tests++; if (cbus_en !== 4'h0) begin fails++; $display("FAIL post_reset_stale got %h exp 0", cbus_en); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_dest  = ($urandom_range(0, 7) == 0) ? 4'h0 : rand_dest();
            wr_data  = $urandom;
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            tests++; if (wr_ready !== (m_q.size() != DEPTH)) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_ready cyc %0d got %b exp %b", i, wr_ready, m_q.size() != DEPTH);
            end
            step();
            tests++; if (cbus_en !== m_en || cbus_out !== m_out || pending !== 3'(m_q.size())) begin
                fails++; bad++;
                if (bad < 10) $display("FAIL rand_bus cyc %0d got %h/%h/%0d exp %h/%h/%0d",
                                       i, cbus_en, cbus_out, pending, m_en, m_out, m_q.size());
            end
        end
        wr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_back_to_back();
        test_idle_drop();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
